// File: rtl/cmd_pkg.sv
// Shared constants for the host command parser: command kinds, ASCII codes and
// parser state encodings.
package cmd_pkg;

    localparam logic [1:0] KIND_BIN  = 2'd0;
    localparam logic [1:0] KIND_FLT  = 2'd1;
    localparam logic [1:0] KIND_TICK = 2'd2;
    localparam logic [1:0] KIND_HACK = 2'd3;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_B  = 8'h62;
    localparam logic [7:0] CH_F  = 8'h66;
    localparam logic [7:0] CH_T  = 8'h74;
    localparam logic [7:0] CH_H  = 8'h68;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_SP1  = 3'd1,
        S_ID   = 3'd2,
        S_IDX  = 3'd3,
        S_VAL  = 3'd4,
        S_SKIP = 3'd5
    } state_t;

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_bin(input logic [7:0] c);
        return (c == CH_0) || (c == CH_1);
    endfunction

endpackage

// File: rtl/cmd_parser_dec_accum.sv
// Decimal accumulator: acc = acc*10 + digit, with an overflow flag that is
// visible in the same cycle as the offending digit and sticky until clr.
module dec_accum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc,
    output logic             ovf
);

    logic [WIDTH+3:0] wide;
    logic             hi_set;
    logic             ovf_q;

    // (2^WIDTH-1)*10 + 9 < 2^(WIDTH+4), so the wide product never wraps.
    assign wide   = ({4'd0, acc} * (WIDTH+4)'(10)) + (WIDTH+4)'(digit);
    assign hi_set = |wide[WIDTH+3:WIDTH];
    assign ovf    = ovf_q | (en & hi_set);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            acc   <= wide[WIDTH-1:0];
            ovf_q <= ovf_q | hi_set;
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// ASCII command-line parser: turns "b"/"f"/"t"/"h" lines into one structured
// command each, held on cmd_* until downstream accepts it.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int ID_W  = 2,
    parameter int IDX_W = 8,
    parameter int VAL_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_kind,
    output logic [ID_W-1:0]  cmd_id,
    output logic [IDX_W-1:0] cmd_index,
    output logic [VAL_W-1:0] cmd_value,
    output logic             err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high. A byte is taken only while no command is pending.

    localparam int IDC_W = $clog2(ID_W + 1);
    localparam int VC_W  = $clog2(VAL_W + 1);
    localparam logic [IDC_W-1:0] ID_MAX  = IDC_W'(ID_W);
    localparam logic [VC_W-1:0]  VAL_MAX = VC_W'(VAL_W);

    state_t             state, state_d;
    logic [1:0]         kind_q, kind_d;
    logic [ID_W-1:0]    id_q;
    logic [IDC_W-1:0]   id_cnt;
    logic [VAL_W-1:0]   bval_q;
    logic [VC_W-1:0]    bval_cnt;
    logic               idx_any, val_any;
    logic               err_d, emit, bad, id_sh, bval_sh;
    logic               byte_ok, clr, idx_en, dval_en, idx_ovf, dval_ovf;
    logic               is_ctl;
    logic [IDX_W-1:0]   idx_acc;
    logic [VAL_W-1:0]   dval_acc;

    assign in_ready = !cmd_valid;
    assign byte_ok  = in_valid && in_ready && (in_data != CH_CR);
    assign clr      = (state == S_OP);
    assign is_ctl   = (kind_q == KIND_TICK) || (kind_q == KIND_HACK);
    assign idx_en   = byte_ok && (state == S_IDX) && is_dec(in_data);
    assign dval_en  = byte_ok && (state == S_VAL) && (kind_q == KIND_FLT) && is_dec(in_data);

    dec_accum #(.WIDTH(IDX_W)) u_idx (
        .clk(clk), .rst(rst), .clr(clr), .en(idx_en),
        .digit(in_data[3:0]), .acc(idx_acc), .ovf(idx_ovf)
    );

    dec_accum #(.WIDTH(VAL_W)) u_dval (
        .clk(clk), .rst(rst), .clr(clr), .en(dval_en),
        .digit(in_data[3:0]), .acc(dval_acc), .ovf(dval_ovf)
    );

    always_comb begin
        state_d = state;
        kind_d  = kind_q;
        err_d   = 1'b0;
        emit    = 1'b0;
        bad     = 1'b0;
        id_sh   = 1'b0;
        bval_sh = 1'b0;
        if (byte_ok) begin
            case (state)
                S_OP: begin
                    if (in_data == CH_B) begin
                        kind_d = KIND_BIN; state_d = S_SP1;
                    end else if (in_data == CH_F) begin
                        kind_d = KIND_FLT; state_d = S_SP1;
                    end else if (in_data == CH_T) begin
                        kind_d = KIND_TICK; state_d = S_SP1;
                    end else if (in_data == CH_H) begin
                        kind_d = KIND_HACK; state_d = S_SP1;
                    end else if (in_data != CH_LF) begin
                        bad = 1'b1;
                    end
                end
                S_SP1: begin
                    if (in_data == CH_SP && !is_ctl) state_d = S_ID;
                    else if (in_data == CH_LF && is_ctl) begin
                        emit = 1'b1; state_d = S_OP;
                    end else bad = 1'b1;
                end
                S_ID: begin
                    if (is_bin(in_data)) begin
                        if (id_cnt == ID_MAX) bad = 1'b1;
                        else id_sh = 1'b1;
                    end else if (in_data == CH_SP && id_cnt != '0) state_d = S_IDX;
                    else bad = 1'b1;
                end
                S_IDX: begin
                    if (is_dec(in_data)) begin
                        if (idx_ovf) bad = 1'b1;
                    end else if (in_data == CH_SP && idx_any) state_d = S_VAL;
                    else bad = 1'b1;
                end
                S_VAL: begin
                    if (kind_q == KIND_BIN && is_bin(in_data)) begin
                        if (bval_cnt == VAL_MAX) bad = 1'b1;
                        else bval_sh = 1'b1;
                    end else if (kind_q == KIND_FLT && is_dec(in_data)) begin
                        if (dval_ovf) bad = 1'b1;
                    end else if (in_data == CH_LF && val_any) begin
                        emit = 1'b1; state_d = S_OP;
                    end else bad = 1'b1;
                end
                S_SKIP: begin
                    if (in_data == CH_LF) state_d = S_OP;
                end
                default: state_d = S_OP;
            endcase
            // A bad LF already ends its line, so skipping would swallow the next one.
            if (bad) begin
                err_d   = 1'b1;
                state_d = (in_data == CH_LF) ? S_OP : S_SKIP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_OP;
            kind_q    <= KIND_BIN;
            id_q      <= '0;
            id_cnt    <= '0;
            bval_q    <= '0;
            bval_cnt  <= '0;
            idx_any   <= 1'b0;
            val_any   <= 1'b0;
            err       <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_kind  <= '0;
            cmd_id    <= '0;
            cmd_index <= '0;
            cmd_value <= '0;
        end else begin
            state  <= state_d;
            kind_q <= kind_d;
            err    <= err_d;
            if (clr) begin
                id_q     <= '0;
                id_cnt   <= '0;
                bval_q   <= '0;
                bval_cnt <= '0;
                idx_any  <= 1'b0;
                val_any  <= 1'b0;
            end else begin
                if (id_sh) begin
                    id_q   <= (id_q << 1) | ID_W'(in_data[0]);
                    id_cnt <= id_cnt + IDC_W'(1);
                end
                if (bval_sh) begin
                    bval_q   <= (bval_q << 1) | VAL_W'(in_data[0]);
                    bval_cnt <= bval_cnt + VC_W'(1);
                end
                idx_any <= idx_any | idx_en;
                val_any <= val_any | dval_en | bval_sh;
            end
            if (emit) begin
                cmd_valid <= 1'b1;
                cmd_kind  <= kind_q;
                cmd_id    <= is_ctl ? '0 : id_q;
                cmd_index <= is_ctl ? '0 : idx_acc;
                cmd_value <= is_ctl ? '0 : ((kind_q == KIND_BIN) ? bval_q : dval_acc);
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: byte driver, command scoreboard with monitor,
// error-pulse counting and a final summary.
module tb_cmd_parser;

  localparam int ID_W  = 2;
  localparam int IDX_W = 8;
  localparam int VAL_W = 64;
  localparam int CW    = 2 + ID_W + IDX_W + VAL_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_kind;
  logic [ID_W-1:0]  cmd_id;
  logic [IDX_W-1:0] cmd_index;
  logic [VAL_W-1:0] cmd_value;
  logic             err;

  logic [CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  int cyc      = 0;

  cmd_parser #(.ID_W(ID_W), .IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_id(cmd_id), .cmd_index(cmd_index),
    .cmd_value(cmd_value), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [ID_W-1:0] id,
                      input logic [IDX_W-1:0] ix, input logic [VAL_W-1:0] v);
    exp_q.push_back({k, id, ix, v});
  endtask

  // monitor: pop on every command transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_seen++;
      if (cmd_valid && cmd_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_unexpected: got %h expected none",
                   {cmd_kind, cmd_id, cmd_index, cmd_value});
        end else begin
          logic [CW-1:0] e;
          e = exp_q.pop_front();
          if ({cmd_kind, cmd_id, cmd_index, cmd_value} !== e) begin
            n_fail++;
            $display("FAIL cmd: got %h expected %h",
                     {cmd_kind, cmd_id, cmd_index, cmd_value}, e);
          end
        end
      end
    end
  end

  // driver
  task automatic send_byte(input logic [7:0] b);
    bit done;
    in_valid = 1'b1;
    in_data  = b;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", CW'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string name);
    check(name, CW'(err_seen), CW'(exp_err));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {cmd_valid, err, cmd_kind, cmd_id, cmd_index, cmd_value[VAL_W-3:0]}, '0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    string s;
    int c0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    check("reset_in_ready", CW'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic binary line
    push(2'd0, 2'd1, 8'd3, 64'd1);
    send_str("b 01 3 1\n");
    wait_drain();
    check_err("err_basic");

    // decimal max then overflow
    push(2'd1, 2'd2, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    send_str("f 10 0 18446744073709551615\n");
    send_str("f 10 0 18446744073709551616\n");
    exp_err++;
    wait_drain();
    check_err("err_dec_ovf");

    // back-pressure on a tick command
    cmd_ready = 1'b0;
    push(2'd2, 2'd0, 8'd0, 64'd0);
    send_str("t\n");
    fork
      send_byte(CH_H_BYTE());
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("hold_valid", CW'(cmd_valid), 1);
          check("hold_in_ready", CW'(in_ready), 0);
          check("hold_kind", CW'(cmd_kind), 2);
        end
        @(posedge clk); #1;
        cmd_ready = 1'b1;
      end
    join
    push(2'd3, 2'd0, 8'd0, 64'd0);
    send_str("\r\n");
    wait_drain();
    check_err("err_backpressure");

    // three malformed lines, then a good one
    send_str("b 011 1 0\n");
    send_str("x\n");
    send_str("b 00 256 1\n");
    exp_err += 3;
    push(2'd0, 2'd0, 8'd5, 64'd0);
    send_str("b 00 5 0\n");
    wait_drain();
    check_err("err_three_bad");

    // index boundary and 64 ones / 64 zeros ok, 65 zeros bad
    s = "b 1 255 ";
    for (int i = 0; i < 64; i++) s = {s, "1"};
    push(2'd0, 2'd1, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF);
    send_str({s, "\n"});
    s = "b 11 0 ";
    for (int i = 0; i < 64; i++) s = {s, "0"};
    push(2'd0, 2'd3, 8'd0, 64'd0);
    send_str({s, "\n"});
    send_str({s, "0\n"});
    exp_err++;
    wait_drain();
    check_err("err_bin_len");

    // reset with a pending command
    cmd_ready = 1'b0;
    send_str("b 11 7 1\n");
    pulse_reset();
    check_outputs_zero("reset_pending_cmd");
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_ready = 1'b1;

    // reset mid-line
    send_str("f 01 2 7");
    pulse_reset();
    check_outputs_zero("reset_mid_line");
    @(posedge clk); #1;
    rst = 1'b0;
    push(2'd1, 2'd1, 8'd2, 64'd9);
    send_str("f 01 2 9\n");
    wait_drain();
    check_err("err_after_reset");

    // back-to-back ticks
    for (int i = 0; i < 4; i++) push(2'd2, 2'd0, 8'd0, 64'd0);
    c0 = cyc;
    send_str("t\nt\nt\nt\n");
    check("b2b_cycles_le_12", CW'((cyc - c0) <= 12), 1);
    wait_drain();
    check_err("err_b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [7:0] CH_H_BYTE();
    return 8'h68;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Byte-stream command decoder that sits directly upstream of component dispatch.
- Consumes the ASCII host command stream one byte per handshake and parses "b", "f", "t" and "h" lines.
- Emits one structured command (kind, component id, field index, value) per line over a valid/ready handshake, so the dispatch stage and components never see ASCII.

Parameters:
- ID_W, 2, component id width; id field limited to ID_W binary digits.
- IDX_W, 8, field index width; decimal index must be < 2^IDX_W.
- VAL_W, 64, value width; binary value ≤ VAL_W digits; decimal value ≤ 2^VAL_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  byte available.
- in_data  in  8  ASCII byte.
- in_ready  out  1  parser accepts byte this cycle.
- cmd_valid  out  1  command held on cmd_* outputs.
- cmd_ready  in  1  downstream accepts command.
- cmd_kind  out  2  KIND_BIN=0, KIND_FLT=1, KIND_TICK=2, KIND_HACK=3.
- cmd_id  out  ID_W  target component id.
- cmd_index  out  IDX_W  field index.
- cmd_value  out  VAL_W  parsed value.
- err  out  1  one-cycle pulse on malformed line.

Behaviour:
- Reset: state S_OP; cmd_valid=0, err=0; cmd_kind/cmd_id/cmd_index/cmd_value=0; all accumulators cleared.
- Grammar: "b" SP id SP index SP binval LF; "f" SP id SP index SP decval LF; "t" LF; "h" LF.
  - id is binary digits; index is decimal; exactly one SP between fields.
  - CR (0x0D) is ignored in every state.
- Byte transfer occurs when in_valid && in_ready.
- in_ready = !cmd_valid. The output buffer is one command deep; no bytes are accepted while a command is pending.
- States: S_OP, S_SP1, S_ID, S_IDX, S_VAL, S_SKIP.
- S_OP:
  - 'b'/'f' -> S_SP1.
  - 't'/'h' -> S_SP1, where LF completes the command.
  - LF -> stay (blank line, silent).
  - Any other byte -> err, S_SKIP.
- S_SP1:
  - SP after 'b'/'f' -> S_ID.
  - LF after 't'/'h' -> emit.
  - Anything else -> err, S_SKIP.
- S_ID:
  - '0'/'1' shifts into id; digit count > ID_W -> err, S_SKIP.
  - SP with ≥1 digit -> S_IDX.
- S_IDX:
  - '0'-'9' computes idx = idx*10 + d; result ≥ 2^IDX_W -> err, S_SKIP.
  - SP with ≥1 digit -> S_VAL.
- S_VAL:
  - 'b' lines accept '0'/'1' only; more than VAL_W digits -> err.
  - 'f' lines accept '0'-'9'; decimal overflow beyond 2^VAL_W-1 -> err.
  - LF with ≥1 digit -> emit.
- Any other byte, or an empty field at SP/LF, in S_ID/S_IDX/S_VAL -> err, S_SKIP.
- S_SKIP: discard bytes until LF, then -> S_OP; no err for the discarded bytes.
- err pulses exactly once per bad line, in the cycle after the offending byte is accepted.
- Emit:
  - cmd_valid rises the cycle after the terminating LF is accepted; outputs are registered and stable while cmd_valid=1.
  - t/h commands output id/index/value = 0.
  - cmd_valid clears the cycle after cmd_valid && cmd_ready; the next byte can be accepted that same following cycle.
- Leading zeros are permitted and do not count toward overflow; only the numeric value matters for decimals.
- For 'b', the digit count (not the value) is limited: 65 zeros is an error.
- rst asserted mid-line or with a pending command drops the partial line and clears cmd_valid immediately (async).

Decomposition:
- Package cmd_pkg holds:
  - KIND_* constants.
  - ASCII constants (SP, LF, CR, '0', '1', '9', 'b', 'f', 't', 'h').
  - Parser state encodings.
- Sub-module dec_accum(WIDTH), used for index and value:
  - Ports: clk, rst, clr, en, digit[3:0], acc[WIDTH-1:0], ovf (sticky until clr).
  - Internally computes acc*10 + d at WIDTH+4 bits and checks the upper bits.

Test Plan:
- "b 01 3 1\n" with cmd_ready=1 -> one cmd_valid pulse; kind=0, id=1, index=3, value=1; err=0.
- "f 10 0 18446744073709551615\n" -> kind=1, id=2, index=0, value=64'hFFFF_FFFF_FFFF_FFFF. Then "f 10 0 18446744073709551616\n" -> err pulse, no cmd_valid.
- "t\n" with cmd_ready held 0 for 5 cycles:
  - cmd_valid held with kind=2, in_ready=0 throughout.
  - The next byte "h" is accepted only after cmd_ready=1; "h\r\n" -> kind=3.
- "b 011 1 0\n" (3-digit id), then "x\n", then "b 00 256 1\n":
  - Exactly 3 err pulses, no commands.
  - A following "b 00 5 0\n" decodes with index=5.
- "f 01 2 7" followed by rst pulse, then "f 01 2 9\n" -> no command from the first line; second yields value=9; all outputs 0 during reset.
- Back-to-back "t\n" ×4 with cmd_ready=1 and in_valid always high -> 4 commands; per 2-byte line, at most one stall cycle per command.
